// File: rtl/id_ex_alu_stage.sv
// ---------------------------------------------------------------------------
// id_ex_alu_stage
//
// ID/EX pipeline register that sits directly in front of the EX-stage ALU.
// It captures one decoded instruction from ID and drives the ALU operands.
// Operands are resolved through MEM/WB forwarding, and the stage supports
// both stall and flush.
//
// Parameters
//   DW  datapath / ALU operand width
//   RW  register-address width
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   id_valid        ID presents an instruction
//   id_ready        stage can accept this cycle (!ex_valid | !ex_stall)
//   id_rs_addr      source register for A
//   id_rt_addr      source register for B
//   id_rs_val       register-file value of rs
//   id_rt_val       register-file value of rt
//   id_imm          extended immediate
//   id_use_imm      1: B comes from id_imm; 0: B comes from rt
//   id_aluop        ALU operation code, passed through unchanged
//   id_dst          destination register
//   ex_stall        downstream cannot advance; hold the entry
//   flush           kill the held entry and any incoming one
//   mem_we          MEM-stage write-back port
//   mem_addr        (same port)
//   mem_data        (same port)
//   wb_we           WB-stage write-back port
//   wb_addr         (same port)
//   wb_data         (same port)
//   alu_a, alu_b    forwarded ALU operands (0 when no valid entry)
//   alu_op          stored ALU op (0 when no valid entry)
//   ex_valid        EX entry is valid
//   ex_dst          destination register of the EX entry
// ---------------------------------------------------------------------------
module id_ex_alu_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [2:0]    id_aluop,
  input  logic [RW-1:0] id_dst,
  input  logic          ex_stall,
  input  logic          flush,
  input  logic          mem_we,
  input  logic [RW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  output logic          ex_valid,
  output logic [RW-1:0] ex_dst
);

  typedef enum logic {
    StEmpty = 1'b0,
    StHeld  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rs_addr_q, rs_addr_d;
  logic [RW-1:0] rt_addr_q, rt_addr_d;
  logic [DW-1:0] a_val_q, a_val_d;
  logic [DW-1:0] b_val_q, b_val_d;
  logic [2:0]    op_q, op_d;
  logic [RW-1:0] dst_q, dst_d;

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  logic          load;

  // MEM beats WB; register 0 is hard-wired and never forwarded.
  function automatic logic [DW-1:0] forward(
    input logic [RW-1:0] src,
    input logic [DW-1:0] stored,
    input logic          m_we,
    input logic [RW-1:0] m_addr,
    input logic [DW-1:0] m_data,
    input logic          w_we,
    input logic [RW-1:0] w_addr,
    input logic [DW-1:0] w_data
  );
    logic [DW-1:0] res;
    res = stored;
    if (src != '0) begin
      if (m_we && (m_addr == src)) begin
        res = m_data;
      end else if (w_we && (w_addr == src)) begin
        res = w_data;
      end
    end
    return res;
  endfunction

  assign ex_valid = (state_q == StHeld);
  assign id_ready = !ex_valid || !ex_stall;
  assign load     = id_valid && id_ready && !flush;

  always_comb begin
    fwd_a = forward(rs_addr_q, a_val_q, mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data);
    fwd_b = forward(rt_addr_q, b_val_q, mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    a_val_d   = a_val_q;
    b_val_d   = b_val_q;
    op_d      = op_q;
    dst_d     = dst_q;

    if (flush) begin
      state_d = StEmpty;
    end else if (load) begin
      state_d   = StHeld;
      rs_addr_d = id_rs_addr;
      a_val_d   = id_rs_val;
      op_d      = id_aluop;
      dst_d     = id_dst;
      if (id_use_imm) begin
        // Address 0 disables B forwarding so the immediate is never replaced.
        rt_addr_d = '0;
        b_val_d   = id_imm;
      end else begin
        rt_addr_d = id_rt_addr;
        b_val_d   = id_rt_val;
      end
    end else begin
      unique case (state_q)
        StHeld: begin
          if (ex_stall) begin
            // Sticky refresh: a producer that retires while we are stalled
            // would otherwise vanish from the forwarding network.
            state_d = StHeld;
            a_val_d = fwd_a;
            b_val_d = fwd_b;
          end else begin
            state_d = StEmpty;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      a_val_q   <= '0;
      b_val_q   <= '0;
      op_q      <= '0;
      dst_q     <= '0;
    end else begin
      state_q   <= state_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      a_val_q   <= a_val_d;
      b_val_q   <= b_val_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
    end
  end

  // ALU inputs are quiet whenever no valid entry is held.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (ex_valid) begin
      alu_a  = fwd_a;
      alu_b  = fwd_b;
      alu_op = op_q;
    end
  end

  assign ex_dst = dst_q;

endmodule
